// File: rtl/hs_env_pkg.sv
// Shared types and default parameter values for the hs_env handshake test environment.
package hs_env_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } prod_state_e;

   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_DEF     = 1024;

endpackage

// File: rtl/hs_sync.sv
// Single-bit multi-flop synchronizer for asynchronous handshake inputs.
module hs_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // shift the raw input into the synchronizer chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   // synchronizer flops, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hs_env.sv
// 4-phase handshake producer/sink environment for an asynchronous pipeline.
// Optional watchdog enabled by defining HS_ENV_TIMEOUT_EN.
module hs_env
   import hs_env_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] n_tokens,
   input  logic             ai,
   input  logic             ro,
   output logic             ri,
   output logic             ao,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent_cnt,
   output logic [CNT_W-1:0] recv_cnt,
   output logic             timeout_err
);

   logic ai_s;
   logic ro_s;

   prod_state_e      state_q, state_d;
   logic [CNT_W-1:0] n_lat_q, n_lat_d;
   logic [CNT_W-1:0] sent_q, sent_d, sent_inc;
   logic [CNT_W-1:0] recv_q, recv_d;
   logic             ri_q, ri_d;
   logic             ao_q, ao_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

`ifdef HS_ENV_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            terr_q, terr_d;
`endif

   hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ai (.clk(clk), .reset(reset), .d(ai), .q(ai_s));
   hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ro (.clk(clk), .reset(reset), .d(ro), .q(ro_s));

   // producer next state, sink tracking and optional watchdog
   always_comb begin
      state_d  = state_q;
      n_lat_d  = n_lat_q;
      sent_d   = sent_q;
      sent_inc = sent_q + {{(CNT_W-1){1'b0}}, 1'b1};
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (n_tokens != {CNT_W{1'b0}}) begin
                  n_lat_d = n_tokens;
                  sent_d  = {CNT_W{1'b0}};
                  state_d = REQ_HI;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ_HI: begin
            if (ai_s) begin
               state_d = REQ_LO;
            end else begin
               state_d = REQ_HI;
            end
         end
         REQ_LO: begin
            if (!ai_s) begin
               sent_d = sent_inc;
               if (sent_inc == n_lat_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = REQ_HI;
               end
            end else begin
               state_d = REQ_LO;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef HS_ENV_TIMEOUT_EN
      // the watchdog measures dwell time in one busy state, not total run time
      terr_d = terr_q;
      if ((state_q == IDLE) || (state_d != state_q)) begin
         wd_d = {WD_W{1'b0}};
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
         wd_d    = {WD_W{1'b0}};
         terr_d  = 1'b1;
         state_d = IDLE;
         done_d  = 1'b0;
      end else begin
         wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
      end
`endif

      ri_d   = (state_d == REQ_HI);
      busy_d = (state_d != IDLE);
      ao_d   = ro_s;
      if (ao_q && !ro_s) begin
         recv_d = recv_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         recv_d = recv_q;
      end
   end

   // producer FSM and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_lat_q <= {CNT_W{1'b0}};
         sent_q  <= {CNT_W{1'b0}};
         recv_q  <= {CNT_W{1'b0}};
         ri_q    <= 1'b0;
         ao_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_lat_q <= n_lat_d;
         sent_q  <= sent_d;
         recv_q  <= recv_d;
         ri_q    <= ri_d;
         ao_q    <= ao_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef HS_ENV_TIMEOUT_EN
   // watchdog counter and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q   <= {WD_W{1'b0}};
         terr_q <= 1'b0;
      end else begin
         wd_q   <= wd_d;
         terr_q <= terr_d;
      end
   end

   assign timeout_err = terr_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_err    = 1'b0;
`endif

   assign ri       = ri_q;
   assign ao       = ao_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sent_cnt = sent_q;
   assign recv_cnt = recv_q;

endmodule
